// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequences a valid/ready byte stream onto a byte-level SPI
// master. It owns chip select, spaces bytes with setup/gap/hold/idle timing,
// hands each received byte back with its last flag and flags a master that
// never goes busy.
module spi_xfer_ctrl #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 0,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk2,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    output logic       csn,
    output logic       active,
    output logic       err,
    output logic [7:0] spi_din,
    output logic       spi_start,
    input  logic       spi_busy,
    input  logic [7:0] spi_dout
);

    // One shared sequencing counter covers setup, gap, hold and the busy
    // timeout (which needs to count to 2), so it is sized for the largest.
    localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_SHG = (MAX_SH > GAP) ? MAX_SH : GAP;
    localparam int SEQ_MAX = (MAX_SHG > 2) ? MAX_SHG : 2;
    localparam int CNT_W   = $clog2(SEQ_MAX) + 1;
    localparam int IDLE_W  = $clog2((CS_IDLE > 1) ? CS_IDLE : 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_GAP     = 3'd5,
        S_NEXT    = 3'd6,
        S_HOLD    = 3'd7
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [7:0]        data_r;
    logic              last_r;
    logic              accept_s;

    // The master is never reset, so IDLE also waits for it to go quiet.
    assign tx_ready = !rst && (((state_r == S_IDLE) && (idle_cnt_r == {IDLE_W{1'b0}}) && !spi_busy)
                               || (state_r == S_NEXT));
    assign accept_s = tx_valid && tx_ready;

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            idle_cnt_r <= IDLE_W'(CS_IDLE);
            data_r     <= 8'h00;
            last_r     <= 1'b0;
            csn        <= 1'b1;
            active     <= 1'b0;
            err        <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_last    <= 1'b0;
            spi_din    <= 8'h00;
            spi_start  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            spi_start <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (idle_cnt_r != {IDLE_W{1'b0}}) begin
                        idle_cnt_r <= idle_cnt_r - IDLE_W'(1);
                    end
                    if (accept_s) begin
                        data_r <= tx_data;
                        last_r <= tx_last;
                        csn    <= 1'b0;
                        active <= 1'b1;
                        err    <= 1'b0;
                        cnt_r  <= {CNT_W{1'b0}};
                        if (CS_SETUP == 0) begin
                            state_r   <= S_START;
                            spi_start <= 1'b1;
                            spi_din   <= tx_data;
                        end else begin
                            state_r <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_r == CNT_W'(CS_SETUP - 1)) begin
                        state_r   <= S_START;
                        spi_start <= 1'b1;
                        spi_din   <= data_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_START: begin
                    // spi_start is high for exactly this one cycle
                    state_r <= S_WAIT_HI;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                S_WAIT_HI: begin
                    if (spi_busy) begin
                        state_r <= S_WAIT_LO;
                    end else if (cnt_r == CNT_W'(1)) begin
                        // master never acknowledged the start: abandon the byte
                        err   <= 1'b1;
                        cnt_r <= {CNT_W{1'b0}};
                        if (CS_HOLD == 0) begin
                            state_r    <= S_IDLE;
                            csn        <= 1'b1;
                            active     <= 1'b0;
                            idle_cnt_r <= IDLE_W'(CS_IDLE);
                        end else begin
                            state_r <= S_HOLD;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!spi_busy) begin
                        rx_data  <= spi_dout;
                        rx_valid <= 1'b1;
                        rx_last  <= last_r;
                        cnt_r    <= {CNT_W{1'b0}};
                        if (last_r) begin
                            if (CS_HOLD == 0) begin
                                state_r    <= S_IDLE;
                                csn        <= 1'b1;
                                active     <= 1'b0;
                                idle_cnt_r <= IDLE_W'(CS_IDLE);
                            end else begin
                                state_r <= S_HOLD;
                            end
                        end else if (GAP > 0) begin
                            state_r <= S_GAP;
                        end else begin
                            state_r <= S_NEXT;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_r == CNT_W'(GAP - 1)) begin
                        state_r <= S_NEXT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    // CSn stays low here for as long as the source stalls
                    if (accept_s) begin
                        data_r    <= tx_data;
                        last_r    <= tx_last;
                        state_r   <= S_START;
                        spi_start <= 1'b1;
                        spi_din   <= tx_data;
                    end
                end
                S_HOLD: begin
                    if (cnt_r == CNT_W'(CS_HOLD - 1)) begin
                        state_r    <= S_IDLE;
                        csn        <= 1'b1;
                        active     <= 1'b0;
                        idle_cnt_r <= IDLE_W'(CS_IDLE);
                        cnt_r      <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    csn     <= 1'b1;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule
